// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-side transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } ps2_state_e;

    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_START_BIT  = 1'b0;
    localparam logic PS2_STOP_BIT   = 1'b1;

    // Parity bit that makes the count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO in front of the PS/2 serialiser; async active-high reset, power-of-2 depth.
module ps2_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-to-host frame transmitter fed by a byte FIFO.
// Optional PS2_TX_PARITY_ERR_EN adds err_inject to corrupt one frame's parity.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       host_inhibit,
`ifdef PS2_TX_PARITY_ERR_EN
    input  logic       err_inject,
`endif
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int         CNT_W    = $clog2(CLK_DIV);
    localparam int         GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e       state_q;
    logic [CNT_W-1:0] phase_cnt_q;
    logic             phase_hi_q;
    logic [3:0]       bit_q;
    logic [9:0]       sr_q;
    logic [GAP_W-1:0] gap_q;
    logic             ps2_clk_q, ps2_data_q, frame_done_q;

    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_dout;
    logic       phase_end, par;

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && !fifo_full),
        .pop_i   (fifo_pop),
        .din_i   (in_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef PS2_TX_PARITY_ERR_EN
    assign par = odd_parity(fifo_dout) ^ err_inject;
`else
    assign par = odd_parity(fifo_dout);
`endif

    assign phase_end = (phase_cnt_q == CNT_W'(CLK_DIV - 1));

    // The head byte leaves the FIFO only once its stop bit has fully gone out,
    // so an aborted frame is retransmitted from the same entry.
    assign fifo_pop = (state_q == SHIFT) && !(host_inhibit && bit_q < STOP_IDX) &&
                      phase_end && !phase_hi_q && (bit_q == STOP_IDX);

    assign in_ready   = !fifo_full;
    assign ps2_clk    = ps2_clk_q;
    assign ps2_data   = ps2_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_cnt_q  <= '0;
            phase_hi_q   <= 1'b1;
            bit_q        <= '0;
            sr_q         <= '1;
            gap_q        <= '0;
            ps2_clk_q    <= 1'b1;
            ps2_data_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !host_inhibit) state_q <= LOAD;
                end
                LOAD: begin
                    sr_q        <= {PS2_STOP_BIT, par, fifo_dout};
                    ps2_data_q  <= PS2_START_BIT;
                    ps2_clk_q   <= 1'b1;
                    phase_cnt_q <= '0;
                    phase_hi_q  <= 1'b1;
                    bit_q       <= '0;
                    state_q     <= SHIFT;
                end
                SHIFT: begin
                    if (host_inhibit && bit_q < STOP_IDX) begin
                        ps2_clk_q  <= 1'b1;
                        ps2_data_q <= 1'b1;
                        gap_q      <= '0;
                        state_q    <= GAP;
                    end else if (!phase_end) begin
                        phase_cnt_q <= phase_cnt_q + CNT_W'(1);
                    end else begin
                        phase_cnt_q <= '0;
                        if (phase_hi_q) begin
                            ps2_clk_q  <= 1'b0;
                            phase_hi_q <= 1'b0;
                        end else if (bit_q == STOP_IDX) begin
                            ps2_clk_q    <= 1'b1;
                            ps2_data_q   <= 1'b1;
                            frame_done_q <= 1'b1;
                            gap_q        <= '0;
                            state_q      <= GAP;
                        end else begin
                            // Data only moves at the start of a high phase.
                            ps2_clk_q  <= 1'b1;
                            ps2_data_q <= sr_q[0];
                            sr_q       <= {1'b1, sr_q[9:1]};
                            bit_q      <= bit_q + 4'd1;
                            phase_hi_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: frames are captured at ps2_clk falling edges and scoreboarded.
module tb_ps2_kbd_tx;

    localparam int CLK_DIV    = 8;
    localparam int GAP_CYCLES = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_CYC  = 22 * CLK_DIV;
    localparam int LIMIT      = 2000;

    logic       clk, rst;
    logic [7:0] in_data;
    logic       in_valid, in_ready, host_inhibit;
    logic       ps2_clk, ps2_data, busy, frame_done;
`ifdef PS2_TX_PARITY_ERR_EN
    logic       err_inject;
`endif

    ps2_kbd_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .host_inhibit (host_inhibit),
`ifdef PS2_TX_PARITY_ERR_EN
        .err_inject   (err_inject),
`endif
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [10:0] exp_q[$];

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic inj);
        logic p;
        p = ~(^d) ^ inj;
        return {1'b1, p, d, 1'b0};
    endfunction

    // ---------------- monitor ----------------
    int          idx = 0;
    int          hi_run = 0;
    int          start_cyc = -1;
    int          last_done_cyc = -1;
    int          done_cnt = 0;
    bit          gap_chk = 0;
    logic [10:0] cap, last_cap;
    logic        prev_clk = 1'b1, prev_data = 1'b1, prev_done = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            idx = 0; hi_run = 0; start_cyc = -1;
            prev_clk = 1'b1; prev_data = 1'b1; prev_done = 1'b0;
        end else begin
            if (idx == 0 && ps2_clk && prev_data && !ps2_data) begin
                start_cyc = cyc;
                if (gap_chk && last_done_cyc >= 0)
                    chk("gap_len", cyc - last_done_cyc, GAP_CYCLES + 2);
            end
            if (prev_clk && !ps2_clk) begin
                if (idx == 0) chk("first_fall", cyc - start_cyc, CLK_DIV);
                cap[idx] = ps2_data;
                idx++;
                if (idx == 11) begin
                    idx = 0;
                    last_cap = cap;
                    chk("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("frame", cap, exp_q.pop_front());
                end
            end
            hi_run = ps2_clk ? hi_run + 1 : 0;
            if (idx != 0 && hi_run > CLK_DIV + 1) idx = 0;
            if (frame_done) begin
                done_cnt++;
                chk("frame_len", cyc - start_cyc, FRAME_CYC);
                chk("done_pulse", prev_done, 0);
                last_done_cyc = cyc;
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
            prev_done = frame_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] d, input logic inj, output int acc_cyc);
        int waited = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        chk("push_accept", waited < LIMIT, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(mk_frame(d, inj));
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < LIMIT) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("done_wait", done_cnt >= target, 1);
    endtask

    task automatic wait_bit(input int target);
        int n = 0;
        while (idx != target && n < LIMIT) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("bit_wait", idx, target);
    endtask

    // ---------------- stimulus ----------------
    int acc, acc5, base, done_before;
    logic [7:0] burst [5] = '{8'h15, 8'h2D, 8'hFF, 8'h00, 8'h81};

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; host_inhibit = 1'b0;
`ifdef PS2_TX_PARITY_ERR_EN
        err_inject = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_clk", ps2_clk, 1);
        chk("rst_data", ps2_data, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Single byte: latency, exact frame bits and length.
        push_byte(8'h1C, 1'b0, acc);
        chk("n_idle", busy, 0);
        @(posedge clk); #1;
        chk("n1_load_busy", busy, 1);
        wait_done(1);
        chk("start_latency", start_cyc - acc, 2);
        chk("frame_1c_bits", last_cap, 11'h438);

        // Back-to-back bytes with the inter-frame gap.
        push_byte(8'hF0, 1'b0, acc);
        push_byte(8'h1C, 1'b0, acc);
        wait_done(2);
        chk("par_f0", last_cap[9], 1);
        gap_chk = 1;
        wait_done(3);
        gap_chk = 0;
        chk("par_1c", last_cap[9], 0);

        // Burst of five into a four-entry FIFO.
        repeat (50) @(negedge clk);
        base = done_cnt;
        for (int i = 0; i < 4; i++) push_byte(burst[i], 1'b0, acc);
        chk("full_ready_low", in_ready, 0);
        push_byte(burst[4], 1'b0, acc5);
        chk("push5_after_pop", acc5, last_done_cyc + 1);
        chk("done_at_push5", done_cnt, base + 1);
        wait_done(base + 5);

        // Host inhibit during bit 4 aborts; byte is resent once.
        repeat (50) @(negedge clk);
        base = done_cnt;
        push_byte(8'h5A, 1'b0, acc);
        wait_bit(5);
        host_inhibit = 1'b1;
        @(posedge clk); #1;
        chk("abort_clk", ps2_clk, 1);
        chk("abort_data", ps2_data, 1);
        chk("abort_busy", busy, 1);
        repeat (80) @(posedge clk);
        #1;
        chk("inhibit_idle", busy, 0);
        chk("inhibit_no_done", done_cnt, base);
        host_inhibit = 1'b0;
        wait_done(base + 1);
        repeat (100) @(posedge clk);
        #1;
        chk("one_done", done_cnt, base + 1);
        chk("abort_drained", exp_q.size(), 0);

        // Reset mid-frame discards everything pending.
        push_byte(8'h33, 1'b0, acc);
        push_byte(8'h44, 1'b0, acc);
        wait_bit(7);
        done_before = done_cnt;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_clk", ps2_clk, 1);
        chk("mid_rst_data", ps2_data, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("no_frame_after_rst", done_cnt, done_before);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_data", ps2_data, 1);

`ifdef PS2_TX_PARITY_ERR_EN
        // Corrupted parity on one frame only.
        base = done_cnt;
        err_inject = 1'b1;
        push_byte(8'h1C, 1'b1, acc);
        repeat (3) @(negedge clk);
        err_inject = 1'b0;
        push_byte(8'h1C, 1'b0, acc);
        wait_done(base + 1);
        chk("inj_par", last_cap[9], 1);
        wait_done(base + 2);
        chk("clean_par", last_cap[9], 0);
`endif

        repeat (10) @(posedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
